// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit for the 32-bit MIPS core.
//
// Owns the program counter, issues one word fetch at a time to instruction memory
// over a valid/ready handshake, and holds each fetched instruction with its PC+4
// at the IF/ID boundary until decode takes it. A taken branch from Execute
// redirects the PC and squashes any in-flight or held fetch.
//
// Ports:
//   clk, rst_n                 core clock, asynchronous active-low reset
//   stall                      decode hazard hold; only blocks the HOLD exit
//   branchTaken, branchTarget  redirect strobe and target from Execute
//   imemReq, imemAddr          registered fetch request and word address
//   imemReady                  memory accepts the request this cycle
//   imemValid, imemData        fetch response
//   ifValid, ifInstr, ifPC4    held instruction and its address + 4 for decode
//   idReady                    decode accepts the held instruction
//
// Build option: define IFU_PERF_CNT_EN to add the fetchCount / flushCount
// performance counter outputs.

module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branchTaken,
    input  logic [31:0] branchTarget,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemReady,
    input  logic        imemValid,
    input  logic [31:0] imemData,
    output logic        ifValid,
    output logic [31:0] ifInstr,
    output logic [31:0] ifPC4,
    input  logic        idReady
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0] fetchCount,
    output logic [31:0] flushCount
`endif
);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StHold} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        drop_q, drop_d;
    logic        imem_req_q, imem_req_d;
    logic [31:0] imem_addr_q, imem_addr_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic [31:0] if_pc4_q, if_pc4_d;
    logic        fetch_inc, flush_inc;
    logic [31:0] redirect_pc, pc_plus4;

    assign redirect_pc = {branchTarget[31:2], 2'b00};
    assign pc_plus4    = pc_q + 32'd4;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        drop_d     = drop_q;
        if_valid_d = if_valid_q;
        if_instr_d = if_instr_q;
        if_pc4_d   = if_pc4_q;
        fetch_inc  = 1'b0;
        flush_inc  = 1'b0;

        unique case (state_q)
            StIdle: state_d = StReq;
            StReq: begin
                // Without imemReady the new pc simply becomes the next presented address.
                if (branchTaken) pc_d = redirect_pc;
                if (imemReady) begin
                    state_d = StWait;
                    if (branchTaken) begin
                        drop_d    = 1'b1;
                        flush_inc = 1'b1;
                    end
                end
            end
            StWait: begin
                if (imemValid) begin
                    drop_d = 1'b0;
                    if (branchTaken) begin
                        pc_d      = redirect_pc;
                        state_d   = StReq;
                        flush_inc = 1'b1;
                    end else if (drop_q) begin
                        state_d = StReq;
                    end else begin
                        if_instr_d = imemData;
                        if_pc4_d   = pc_plus4;
                        if_valid_d = 1'b1;
                        pc_d       = pc_plus4;
                        state_d    = StHold;
                        fetch_inc  = 1'b1;
                    end
                end else if (branchTaken) begin
                    // Response still in flight: remember to discard it.
                    pc_d      = redirect_pc;
                    drop_d    = 1'b1;
                    flush_inc = 1'b1;
                end
            end
            StHold: begin
                if (branchTaken) begin
                    pc_d       = redirect_pc;
                    if_valid_d = 1'b0;
                    state_d    = StReq;
                    flush_inc  = 1'b1;
                end else if (idReady && !stall) begin
                    if_valid_d = 1'b0;
                    state_d    = StReq;
                end
            end
            default: state_d = StIdle;
        endcase

        // Request outputs are registered; the address only moves while requesting.
        imem_req_d  = (state_d == StReq);
        imem_addr_d = (state_d == StReq) ? pc_d : imem_addr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            pc_q        <= RESET_PC;
            drop_q      <= 1'b0;
            imem_req_q  <= 1'b0;
            imem_addr_q <= RESET_PC;
            if_valid_q  <= 1'b0;
            if_instr_q  <= 32'h0;
            if_pc4_q    <= 32'h0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            drop_q      <= drop_d;
            imem_req_q  <= imem_req_d;
            imem_addr_q <= imem_addr_d;
            if_valid_q  <= if_valid_d;
            if_instr_q  <= if_instr_d;
            if_pc4_q    <= if_pc4_d;
        end
    end

    assign imemReq  = imem_req_q;
    assign imemAddr = imem_addr_q;
    assign ifValid  = if_valid_q;
    assign ifInstr  = if_instr_q;
    assign ifPC4    = if_pc4_q;

`ifdef IFU_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q <= 32'h0;
            flush_cnt_q <= 32'h0;
        end else begin
            if (fetch_inc) fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (flush_inc) flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign fetchCount = fetch_cnt_q;
    assign flushCount = flush_cnt_q;
`else
    logic unused_inc;
    assign unused_inc = fetch_inc ^ flush_inc;
`endif

endmodule
